// File: rtl/bp_nbf_stream_loader.sv
// Streaming NBF loader: takes {opcode, addr, data} packets from a valid/ready link and issues them
// as BedRock uncached I/O commands on one of num_ch_p credit-tracked channels, with read-back verify.
module bp_nbf_stream_loader
  #(parameter int paddr_width_p   = 40
  , parameter int did_width_p     = 3
  , parameter int lce_id_width_p  = 7
  , parameter int num_ch_p        = 1
  , parameter int ch_sel_lsb_p    = 28
  , parameter int io_data_width_p = 64
  , parameter int credits_p       = 16
  , parameter int err_cnt_width_p = 16
  , localparam int naddr_lp            = (paddr_width_p + 3) / 4 * 4
  , localparam int nbf_width_lp        = 8 + naddr_lp + 64
  , localparam int mem_header_width_lp = did_width_p + lce_id_width_p + 3 + paddr_width_p + 8
  )
  (input  logic                                        clk_i
  , input  logic                                       reset_i
  , input  logic [lce_id_width_p-1:0]                  lce_id_i
  , input  logic [did_width_p-1:0]                     did_i
  , input  logic [nbf_width_lp-1:0]                    nbf_i
  , input  logic                                       nbf_v_i
  , output logic                                       nbf_ready_and_o
  , output logic [num_ch_p*mem_header_width_lp-1:0]    io_cmd_header_o
  , output logic [num_ch_p*io_data_width_p-1:0]        io_cmd_data_o
  , output logic [num_ch_p-1:0]                        io_cmd_v_o
  , input  logic [num_ch_p-1:0]                        io_cmd_ready_and_i
  , input  logic [num_ch_p*mem_header_width_lp-1:0]    io_resp_header_i
  , input  logic [num_ch_p*io_data_width_p-1:0]        io_resp_data_i
  , input  logic [num_ch_p-1:0]                        io_resp_v_i
  , output logic [num_ch_p-1:0]                        io_resp_ready_and_o
  , output logic                                       done_o
  , output logic                                       error_o
  , output logic [err_cnt_width_p-1:0]                 mismatch_count_o
  );

  // Header layout, LSB first: msg_type[3:0], subop[3:0], addr, size[2:0], lce_id, did.
  localparam int ch_w_lp = (num_ch_p > 1) ? $clog2(num_ch_p) : 1;
  localparam int cr_w_lp = $clog2(credits_p + 1);
  localparam logic [3:0] msg_uc_rd_lp   = 4'd2;
  localparam logic [3:0] msg_uc_wr_lp   = 4'd3;
  localparam logic [3:0] subop_store_lp = 4'd0;

  if (io_data_width_p < 64) begin : g_chk_width
    $error("io_data_width_p must be at least 64");
  end
  if ((num_ch_p < 1) || ((num_ch_p & (num_ch_p - 1)) != 0)) begin : g_chk_pow2
    $error("num_ch_p must be a power of two");
  end
  if ((num_ch_p > 1) && (ch_sel_lsb_p + $clog2(num_ch_p) > paddr_width_p)) begin : g_chk_sel
    $error("channel select field exceeds paddr_width_p");
  end

  typedef enum logic [2:0] {e_reset, e_send, e_read_wait, e_fence, e_drain, e_done} state_e;

  function automatic logic [63:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 64'h0000_0000_0000_00FF;
      2'd1:    return 64'h0000_0000_0000_FFFF;
      2'd2:    return 64'h0000_0000_FFFF_FFFF;
      default: return '1;
    endcase
  endfunction

  function automatic logic [io_data_width_p-1:0] replicate(input logic [63:0] d, input logic [1:0] size);
    logic [io_data_width_p-1:0] r;
    int nb;
    r  = '0;
    nb = 1 << size;
    for (int i = 0; i < io_data_width_p / 8; i++) begin
      r[i*8 +: 8] = d[(i % nb)*8 +: 8];
    end
    return r;
  endfunction

  state_e state_q, state_d;
  logic                       pkt_v_q, pkt_v_d;
  logic                       pkt_rd_q;
  logic [1:0]                 pkt_size_q;
  logic [naddr_lp-1:0]        pkt_addr_q;
  logic [63:0]                pkt_data_q;
  logic [ch_w_lp-1:0]         pkt_ch_q;
  logic [cr_w_lp-1:0]         credit_q [num_ch_p];
  logic [cr_w_lp-1:0]         credit_d [num_ch_p];
  logic [num_ch_p-1:0]        armed_q;
  logic                       err_q, err_d;
  logic [err_cnt_width_p-1:0] cnt_q, cnt_d;

  logic [7:0]          in_op;
  logic [naddr_lp-1:0] in_addr;
  logic [63:0]         in_data;
  logic [ch_w_lp-1:0]  in_ch;
  logic                in_finish, in_fence, accept, pkt_load;
  logic [num_ch_p-1:0] cmd_v, cmd_hs;
  logic                cmd_fire, credits_zero;
  logic [mem_header_width_lp-1:0] rd_resp_hdr, cmd_hdr;
  logic [63:0]         rd_resp_data;
  logic                rd_resp_v, rd_mismatch;
  logic                unused_bits;

  assign in_op     = nbf_i[nbf_width_lp-1 -: 8];
  assign in_addr   = nbf_i[64 +: naddr_lp];
  assign in_data   = nbf_i[63:0];
  assign in_finish = (in_op == 8'hFF);
  assign in_fence  = (in_op == 8'hFE);

  if (num_ch_p > 1) begin : g_ch_sel
    assign in_ch = in_addr[ch_sel_lsb_p +: $clog2(num_ch_p)];
  end else begin : g_ch_single
    assign in_ch = '0;
  end

  always_comb begin
    cmd_v = '0;
    if ((state_q == e_send) && pkt_v_q && (credit_q[pkt_ch_q] < cr_w_lp'(credits_p))) begin
      cmd_v[pkt_ch_q] = 1'b1;
    end
  end

  assign cmd_hs   = cmd_v & io_cmd_ready_and_i;
  assign cmd_fire = |cmd_hs;
  // A read handshake moves us to e_read_wait, so intake is withheld in that cycle too.
  assign nbf_ready_and_o = (state_q == e_send) & (~pkt_v_q | (cmd_fire & ~pkt_rd_q));
  assign accept   = nbf_v_i & nbf_ready_and_o;
  assign pkt_load = accept & ~in_finish & ~in_fence;

  assign rd_resp_hdr  = io_resp_header_i[pkt_ch_q*mem_header_width_lp +: mem_header_width_lp];
  assign rd_resp_data = io_resp_data_i[pkt_ch_q*io_data_width_p +: 64];
  assign rd_resp_v    = io_resp_v_i[pkt_ch_q] & (rd_resp_hdr[3:0] == msg_uc_rd_lp);
  assign rd_mismatch  = |((rd_resp_data ^ pkt_data_q) & size_mask(pkt_size_q));

  always_comb begin
    credits_zero = 1'b1;
    for (int c = 0; c < num_ch_p; c++) begin
      if (credit_q[c] != '0) credits_zero = 1'b0;
    end
  end

  // Responses at zero credit (e.g. leftovers from before a reset) are dropped, never underflowing.
  always_comb begin
    for (int c = 0; c < num_ch_p; c++) begin
      credit_d[c] = credit_q[c];
      if (cmd_hs[c] && !(io_resp_v_i[c] && credit_q[c] != '0)) begin
        credit_d[c] = credit_q[c] + 1'b1;
      end else if (!cmd_hs[c] && io_resp_v_i[c] && credit_q[c] != '0) begin
        credit_d[c] = credit_q[c] - 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pkt_v_d = pkt_v_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      e_reset: state_d = e_send;
      e_send: begin
        if (cmd_fire) begin
          pkt_v_d = 1'b0;
          if (pkt_rd_q) state_d = e_read_wait;
        end
        if (accept) begin
          if (in_finish)     state_d = e_drain;
          else if (in_fence) state_d = e_fence;
          else               pkt_v_d = 1'b1;
        end
      end
      e_read_wait: begin
        if (rd_resp_v) begin
          state_d = e_send;
          if (rd_mismatch) begin
            err_d = 1'b1;
            if (~&cnt_q) cnt_d = cnt_q + 1'b1;
          end
        end
      end
      e_fence: if (credits_zero) state_d = e_send;
      e_drain: if (credits_zero) state_d = e_done;
      e_done:  state_d = e_done;
      default: state_d = e_reset;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_reset;
      pkt_v_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      armed_q <= '0;
      for (int c = 0; c < num_ch_p; c++) credit_q[c] <= '0;
    end else begin
      state_q <= state_d;
      pkt_v_q <= pkt_v_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_q | cmd_hs;
      for (int c = 0; c < num_ch_p; c++) credit_q[c] <= credit_d[c];
    end
  end

  always_ff @(posedge clk_i) begin
    if (pkt_load) begin
      pkt_rd_q   <= in_op[5];
      pkt_size_q <= in_op[1:0];
      pkt_addr_q <= in_addr;
      pkt_data_q <= in_data;
      pkt_ch_q   <= in_ch;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < num_ch_p; c++) begin
      if (!reset_i && armed_q[c] && io_resp_v_i[c]) begin
        assert (credit_q[c] != '0) else $error("response on channel %0d with no outstanding command", c);
      end
    end
  end

  assign cmd_hdr = {did_i, lce_id_i, 1'b0, pkt_size_q, pkt_addr_q[paddr_width_p-1:0],
                    subop_store_lp, (pkt_rd_q ? msg_uc_rd_lp : msg_uc_wr_lp)};

  assign io_cmd_v_o          = cmd_v;
  assign io_cmd_header_o     = {num_ch_p{cmd_hdr}};
  assign io_cmd_data_o       = {num_ch_p{replicate(pkt_data_q, pkt_size_q)}};
  assign io_resp_ready_and_o = '1;
  assign done_o              = (state_q == e_done);
  assign error_o             = err_q;
  assign mismatch_count_o    = cnt_q;
  assign unused_bits         = ^{io_resp_header_i, io_resp_data_i, pkt_addr_q};

endmodule
